ifu_fetch: RTL

// - Fetch unit: the consumer end of the ALU redirect interface (pc_out/pc_load) and the producer of the
//   {instr_tag, instr} stream that reaches the ALU through decode.
// - Generates sequential fetch addresses and issues in-order requests to instruction memory.
// - Buffers returned words, each tagged with its PC, in an instruction FIFO.
// - On redirect, flushes the FIFO and discards stale in-flight responses.

---
 rtl/ifu_fetch.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: credit-limited in-order imem requests, PC-tagged instruction FIFO, redirect flush.
// Optional IFU_PERF_CNT_EN adds perf_fetched/perf_dropped event counters.
module ifu_fetch #(
    parameter int unsigned     XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_PC   = '0,
    parameter int unsigned     FIFO_DEPTH = 4,
    parameter int unsigned     MAX_OUTST  = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            pc_load,
    input  logic [XLEN-1:0] pc_out,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    output logic            fetch_valid,
    input  logic            fetch_ready,
    output logic [XLEN-1:0] fetch_instr_tag,
    output logic [31:0]     fetch_instr
`ifdef IFU_PERF_CNT_EN
    ,
    output logic [31:0]     perf_fetched,
    output logic [31:0]     perf_dropped
`endif
);

    localparam int unsigned OW = $clog2(MAX_OUTST + 1);
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned TW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
    localparam int unsigned SW = CW + 1;

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [OW-1:0]   outst_q, outst_d, drop_q, drop_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [AW-1:0]   wr_q, wr_d, rd_q, rd_d;
    logic [TW-1:0]   tq_wr_q, tq_wr_d, tq_rd_q, tq_rd_d;

    logic [XLEN-1:0] tq_q       [MAX_OUTST];
    logic [XLEN-1:0] fifo_tag_q [FIFO_DEPTH];
    logic [31:0]     fifo_data_q[FIFO_DEPTH];

    logic credit_ok, req_valid, req_fire;
    logic rsp_take, rsp_drop, rsp_keep, head_valid, pop;

    function automatic logic [TW-1:0] tq_inc(input logic [TW-1:0] p);
        return (p == TW'(MAX_OUTST - 1)) ? '0 : p + TW'(1);
    endfunction

    // Handshake qualification from registered counts only
    always_comb begin
        credit_ok  = (outst_q < OW'(MAX_OUTST)) &&
                     ((SW'(outst_q) + SW'(cnt_q)) < SW'(FIFO_DEPTH));
        req_valid  = !rst && !pc_load && credit_ok;
        req_fire   = req_valid && imem_req_ready;
        rsp_take   = imem_rsp_valid && (outst_q != '0);
        rsp_drop   = rsp_take && (pc_load || (drop_q != '0));
        rsp_keep   = rsp_take && !rsp_drop;
        head_valid = !rst && !pc_load && (cnt_q != '0);
        pop        = head_valid && fetch_ready;
    end

    // Next state; a redirect leaves every still-outstanding request marked for discard
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        drop_d     = drop_q;
        cnt_d      = cnt_q;
        wr_d       = wr_q;
        rd_d       = rd_q;
        tq_wr_d    = tq_wr_q;
        tq_rd_d    = tq_rd_q;
        outst_d    = outst_q + OW'(req_fire) - OW'(rsp_take);
        if (pc_load) begin
            fetch_pc_d = pc_out & ~XLEN'(3);
            drop_d     = outst_d;
            cnt_d      = '0;
            wr_d       = '0;
            rd_d       = '0;
            tq_wr_d    = '0;
            tq_rd_d    = '0;
        end else begin
            if (req_fire) begin
                fetch_pc_d = fetch_pc_q + XLEN'(4);
                tq_wr_d    = tq_inc(tq_wr_q);
            end
            if (rsp_drop) begin
                drop_d = drop_q - OW'(1);
            end
            if (rsp_keep) begin
                tq_rd_d = tq_inc(tq_rd_q);
                wr_d    = wr_q + AW'(1);
            end
            if (pop) begin
                rd_d = rd_q + AW'(1);
            end
            cnt_d = cnt_q + CW'(rsp_keep) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            outst_q    <= '0;
            drop_q     <= '0;
            cnt_q      <= '0;
            wr_q       <= '0;
            rd_q       <= '0;
            tq_wr_q    <= '0;
            tq_rd_q    <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            outst_q    <= outst_d;
            drop_q     <= drop_d;
            cnt_q      <= cnt_d;
            wr_q       <= wr_d;
            rd_q       <= rd_d;
            tq_wr_q    <= tq_wr_d;
            tq_rd_q    <= tq_rd_d;
        end
    end

    // Tag queue and instruction FIFO storage (no reset needed, guarded by counts)
    always_ff @(posedge clk) begin
        if (req_fire) begin
            tq_q[tq_wr_q] <= fetch_pc_q;
        end
        if (rsp_keep) begin
            fifo_tag_q[wr_q]  <= tq_q[tq_rd_q];
            fifo_data_q[wr_q] <= imem_rsp_data;
        end
    end

`ifdef IFU_PERF_CNT_EN
    logic [31:0] perf_fetched_q, perf_dropped_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetched_q <= '0;
            perf_dropped_q <= '0;
        end else begin
            perf_fetched_q <= perf_fetched_q + 32'(rsp_keep);
            perf_dropped_q <= perf_dropped_q + 32'(rsp_drop) + (pc_load ? 32'(cnt_q) : 32'd0);
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_dropped = perf_dropped_q;
`endif

    assign imem_req_valid  = req_valid;
    assign imem_req_addr   = fetch_pc_q;
    assign fetch_valid     = head_valid;
    assign fetch_instr_tag = head_valid ? fifo_tag_q[rd_q] : '0;
    assign fetch_instr     = head_valid ? fifo_data_q[rd_q] : '0;

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (!rst) begin
            assert (!(imem_rsp_valid && (outst_q == '0)));
            assert (outst_q <= OW'(MAX_OUTST));
            assert (cnt_q <= CW'(FIFO_DEPTH));
            assert (drop_q <= outst_q);
        end
    end
`endif

endmodule
